// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the writeback path.
//   REG_ADDR_W : register file address width
//   DATA_W     : register file data width
//   wb_entry_t : one queued mul/div writeback {rd, data, killed}
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic                  killed;  // a newer pipeline write made this result stale
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small result FIFO for mul/div writebacks, with per-entry kill bits.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_rd/data    store a new entry at the tail (caller guarantees not full)
//   kill_en, kill_rd      mark every queued entry (and a same-cycle push) with rd == kill_rd killed
//   pop                   drop the head entry (caller guarantees not empty)
//   head                  current head entry
//   count, empty          registered occupancy
//   q_rs, q_rt            hazard query registers
//   rs_pending/rt_pending a live (valid, not killed) entry targets the query register
module wb_result_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [AW:0]           count,
  output logic                  empty,
  input  logic [REG_ADDR_W-1:0] q_rs,
  input  logic [REG_ADDR_W-1:0] q_rt,
  output logic                  rs_pending,
  output logic                  rt_pending
);

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              rs_hit, rt_hit;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    // Kill first so a same-cycle push is not overwritten by the scan.
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (entries_q[i].rd == kill_rd)) begin
          entries_d[i].killed = 1'b1;
        end
      end
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end

    // The pipeline result is always newer than anything arriving from mul/div.
    if (push) begin
      entries_d[wr_ptr_q].rd     = push_rd;
      entries_d[wr_ptr_q].data   = push_data;
      entries_d[wr_ptr_q].killed = kill_en && (push_rd == kill_rd);
      valid_d[wr_ptr_q]          = 1'b1;
      wr_ptr_d                   = wr_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '{default: '0};
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Pending looks only at registered state: an entry popped this cycle still reports.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !entries_q[i].killed && (entries_q[i].rd == q_rs)) rs_hit = 1'b1;
      if (valid_q[i] && !entries_q[i].killed && (entries_q[i].rd == q_rt)) rt_hit = 1'b1;
    end
  end

  assign rs_pending = (q_rs != '0) && rs_hit;
  assign rt_pending = (q_rt != '0) && rt_hit;
  assign head       = entries_q[rd_ptr_q];
  assign count      = count_q;
  assign empty      = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding the register file write port.
// Merges the single-cycle pipeline result (no backpressure, always wins) with
// mul/div results buffered in wb_result_fifo and drained in idle cycles.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data      pipeline result, always accepted
//   md_valid/md_rd/md_data/md_ready   mul/div result handshake
//   q_rs/q_rt, rs_pending/rt_pending  hazard query
//   RFWr/A3/WD                        registered register-file write port
//   work                              RFWr | rst, lets the RF clear itself on reset
//   q_count                           FIFO occupancy
//
// Handshake: a mul/div result transfers on a cycle where md_valid && md_ready.
// md_ready depends only on registered occupancy, so a full FIFO refuses even in
// a cycle where it pops. A transfer with md_rd == 0 completes but is dropped.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        rs_pending,
  output logic        rt_pending,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic        work,
  output logic [AW:0] q_count
);

  logic        pipe_wr;
  logic        push;
  logic        pop;
  logic        empty;
  logic [AW:0] count;
  wb_entry_t   head;

  logic        rf_wr_q, rf_wr_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;

  // A pipeline write to r0 is treated as an idle slot so the FIFO can drain.
  assign pipe_wr  = pipe_valid && (pipe_rd != '0);
  assign md_ready = (count < (AW+1)'(DEPTH));
  assign push     = md_valid && md_ready && (md_rd != '0);
  assign pop      = !pipe_wr && !empty;

  wb_result_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (md_rd),
    .push_data  (md_data),
    .kill_en    (pipe_wr),
    .kill_rd    (pipe_rd),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending)
  );

  // A killed head is consumed silently; address/data hold like an idle cycle.
  always_comb begin
    rf_wr_d = 1'b0;
    a3_d    = a3_q;
    wd_d    = wd_q;
    if (pipe_wr) begin
      rf_wr_d = 1'b1;
      a3_d    = pipe_rd;
      wd_d    = pipe_data;
    end else if (pop && !head.killed) begin
      rf_wr_d = 1'b1;
      a3_d    = head.rd;
      wd_d    = head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_q <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      rf_wr_q <= rf_wr_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
    end
  end

  assign RFWr    = rf_wr_q;
  assign A3      = a3_q;
  assign WD      = wd_q;
  assign work    = rf_wr_q | rst;
  assign q_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk, rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  q_rs, q_rt;
  logic        rs_pending, rt_pending;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        work;
  logic [AW:0] q_count;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .q_rs(q_rs), .q_rt(q_rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .RFWr(RFWr), .A3(A3), .WD(WD), .work(work), .q_count(q_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // Queue of pending mul/div results: {killed, rd, data}
  logic [37:0] exp_q[$];
  logic        exp_rfwr;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  logic [31:0] obs_rf [32];
  int          n_checks, n_fail;
  int          n_writes;     // observed RF writes
  logic        last_accept;  // observed handshake of the last cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic model_pending(input logic [4:0] q);
    logic hit = 1'b0;
    if (q == 5'd0) return 1'b0;
    foreach (exp_q[i]) if (!exp_q[i][37] && exp_q[i][36:32] == q) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_rfwr = 1'b0;
    exp_a3   = '0;
    exp_wd   = '0;
  endtask

  // One clock cycle. Inputs must already be driven; combinational outputs are
  // checked at the falling edge, registered outputs 1 time unit after the rising edge.
  task automatic cycle();
    logic        ready_e, pwr;
    logic [37:0] e;
    @(negedge clk);
    ready_e = (exp_q.size() < DEPTH);
    chk("md_ready", md_ready, ready_e);
    chk("rs_pending", rs_pending, model_pending(q_rs));
    chk("rt_pending", rt_pending, model_pending(q_rt));
    chk("work", work, exp_rfwr | rst);
    last_accept = md_valid && md_ready;
    @(posedge clk);
    if (!rst) begin
      pwr = pipe_valid && (pipe_rd != 5'd0);
      if (pwr) begin
        exp_rfwr = 1'b1; exp_a3 = pipe_rd; exp_wd = pipe_data;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i][36:32] == pipe_rd) begin
            e = exp_q[i]; e[37] = 1'b1; exp_q[i] = e;
          end
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e[37]) begin exp_rfwr = 1'b1; exp_a3 = e[36:32]; exp_wd = e[31:0]; end
        else exp_rfwr = 1'b0;
      end else begin
        exp_rfwr = 1'b0;
      end
      if (md_valid && ready_e && md_rd != 5'd0)
        exp_q.push_back({pwr && (md_rd == pipe_rd), md_rd, md_data});
    end
    #1;
    chk("RFWr", RFWr, exp_rfwr);
    chk("A3", A3, exp_a3);
    chk("WD", WD, exp_wd);
    chk("q_count", q_count, exp_q.size());
    chk("r0_guard", RFWr && (A3 == 5'd0), 1'b0);
    if (RFWr === 1'b1) begin
      obs_rf[A3] = WD;
      n_writes++;
    end
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, w0;
    n_checks = 0; n_fail = 0; n_writes = 0; last_accept = 1'b0;
    foreach (obs_rf[i]) obs_rf[i] = '0;
    idle_inputs();
    q_rs = '0; q_rt = '0;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RFWr", RFWr, 1'b0);
    chk("rst_A3", A3, 5'd0);
    chk("rst_WD", WD, 32'd0);
    chk("rst_q_count", q_count, 0);
    chk("rst_work", work, 1'b1);
    chk("rst_md_ready", md_ready, 1'b1);
    rst = 1'b0;

    // Test 1: single mul/div result, pipe idle
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h12345678;
    cycle();
    chk("t1_qcount", q_count, 1);
    idle_inputs();
    cycle();
    chk("t1_RFWr", RFWr, 1'b1);
    chk("t1_A3", A3, 5'd5);
    chk("t1_WD", WD, 32'h12345678);
    chk("t1_qcount_back", q_count, 0);

    // Test 2: pipeline holds rd=3 for 6 cycles while 5 results are offered
    k = 0;
    for (int c = 0; c < 6; c++) begin
      pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = $urandom;
      md_valid = (k < 5); md_rd = 5'(8 + k); md_data = $urandom;
      cycle();
      if (last_accept) k++;
    end
    chk("t2_accepts", k, 4);
    chk("t2_qcount_full", q_count, 4);
    chk("t2_ready_low", md_ready, 1'b0);
    pipe_valid = 1'b0; pipe_rd = '0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      md_valid = 1'b1; md_rd = 5'(8 + k); md_data = $urandom;
      cycle();
      if (last_accept) k++;
    end
    chk("t2_fifth_accepted", k, 5);
    idle_inputs();
    repeat (6) cycle();

    // Test 3: stale-write kill
    q_rs = 5'd7;
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = $urandom;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h5555_0007;
    cycle();
    chk("t3_pend_before", rs_pending, 1'b1);
    md_valid = 1'b0;
    pipe_rd = 5'd7; pipe_data = 32'h0000_AAAA;
    cycle();
    chk("t3_pend_after", rs_pending, 1'b0);
    idle_inputs();
    cycle();
    chk("t3_killed_pop", RFWr, 1'b0);
    chk("t3_qcount", q_count, 0);
    chk("t3_r7", obs_rf[7], 32'h0000_AAAA);
    q_rs = '0;

    // Test 4: r0 traffic only, then drain during pipe_rd=0 cycles
    w0 = n_writes;
    for (int c = 0; c < 5; c++) begin
      pipe_valid = $urandom_range(0, 1); pipe_rd = 5'd0; pipe_data = $urandom;
      md_valid = 1'b1; md_rd = 5'd0; md_data = $urandom;
      cycle();
    end
    chk("t4_no_writes", n_writes - w0, 0);
    chk("t4_qcount", q_count, 0);
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = $urandom;
    for (int c = 0; c < 2; c++) begin
      md_valid = 1'b1; md_rd = 5'(20 + c); md_data = $urandom;
      cycle();
    end
    md_valid = 1'b0; pipe_rd = 5'd0;
    repeat (3) cycle();
    chk("t4_drained", q_count, 0);
    chk("t4_r21", obs_rf[21], exp_wd);

    // Test 5: reset with 3 entries queued
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = $urandom;
    for (int c = 0; c < 3; c++) begin
      md_valid = 1'b1; md_rd = 5'(13 + c); md_data = $urandom;
      cycle();
    end
    chk("t5_qcount_pre", q_count, 3);
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_RFWr", RFWr, 1'b0);
    chk("t5_A3", A3, 5'd0);
    chk("t5_WD", WD, 32'd0);
    chk("t5_work", work, 1'b1);
    chk("t5_qcount", q_count, 0);
    cycle();
    rst = 1'b0;
    w0 = n_writes;
    repeat (6) cycle();
    chk("t5_no_writes", n_writes - w0, 0);

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      pipe_valid = ($urandom_range(0, 99) < 45);
      pipe_rd    = 5'($urandom_range(0, 7));
      pipe_data  = $urandom;
      md_valid   = ($urandom_range(0, 99) < 60);
      md_rd      = 5'($urandom_range(0, 7));
      md_data    = $urandom;
      q_rs       = 5'($urandom_range(0, 7));
      q_rt       = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();
    chk("final_empty", q_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
